// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the request/hold arbiter clients and monitors
package arb_pkg;

    localparam int ARB_LEN_W = 4;
    localparam int ARB_TAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BURST,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic [ARB_LEN_W-1:0] len;
        logic [ARB_TAG_W-1:0] tag;
    } arb_desc_t;

endpackage

// File: rtl/arb_cmd_slot.sv
// rtl/arb_cmd_slot.sv - one-entry valid/ready descriptor register
module arb_cmd_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         pop
);

    logic         valid;
    logic [W-1:0] data;
    logic         push;

    // ready comes straight from the register so the producer never sees a comb path
    assign in_ready  = ~valid;
    assign push      = in_valid & ~valid;
    assign out_valid = valid;
    assign out_data  = data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= in_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/arb_hold_requester.sv
// rtl/arb_hold_requester.sv - burst initiator driving req/hold toward one round-robin arbiter port
module arb_hold_requester
    import arb_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter int TAG_W  = 4,
    parameter int WAIT_W = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              req,
    output logic              hold,
    input  logic              gnt,
    output logic              beat_fire,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              beat_last,
    output logic [TAG_W-1:0]  beat_tag,
    output logic              done,
    output logic              err,
    output logic [WAIT_W-1:0] wait_max
);

    arb_state_t              state, state_nxt;
    logic [LEN_W-1:0]        idx, idx_nxt;
    logic [LEN_W-1:0]        act_len;
    logic [TAG_W-1:0]        act_tag;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    err_r;
    logic [WAIT_W-1:0]       wait_max_r;
    logic                    pend_valid;
    logic [LEN_W+TAG_W-1:0]  pend_data;
    logic                    load;
    logic                    set_err;
    logic                    is_last;

    arb_cmd_slot #(
        .W (LEN_W + TAG_W)
    ) u_slot (
        .clk       (CLK),
        .rst_n     (rst_n),
        .in_valid  (cmd_valid),
        .in_ready  (cmd_ready),
        .in_data   ({cmd_len, cmd_tag}),
        .out_valid (pend_valid),
        .out_data  (pend_data),
        .pop       (load)
    );

    assign is_last = (idx == act_len);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        set_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (gnt) begin
                    if (is_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_BURST;
                        idx_nxt   = idx + LEN_W'(1);
                    end
                end
            end
            ST_BURST: begin
                // losing the grant mid-burst re-arbitrates and resumes at the same beat
                if (gnt) begin
                    if (is_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = idx + LEN_W'(1);
                    end
                end else begin
                    set_err   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                if (pend_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (load) begin
            idx_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            act_len    <= '0;
            act_tag    <= '0;
            wait_cnt   <= '0;
            err_r      <= 1'b0;
            wait_max_r <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                act_len <= pend_data[LEN_W+TAG_W-1:TAG_W];
                act_tag <= pend_data[TAG_W-1:0];
            end
            if (set_err) begin
                err_r <= 1'b1;
            end
            if (state == ST_REQ) begin
                if (gnt) begin
                    wait_cnt <= '0;
                    if (wait_cnt > wait_max_r) begin
                        wait_max_r <= wait_cnt;
                    end
                end else if (wait_cnt != {WAIT_W{1'b1}}) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

    // req/hold are pure state decodes: gnt is combinational from them on the arbiter side
    assign req       = (state == ST_REQ) || (state == ST_BURST);
    assign hold      = (state == ST_BURST);
    assign beat_fire = req & gnt;
    assign beat_idx  = idx;
    assign beat_last = req & is_last;
    assign beat_tag  = act_tag;
    assign done      = (state == ST_DONE);
    assign err       = err_r;
    assign wait_max  = wait_max_r;

endmodule

// File: tb/tb_arb_hold_requester.sv
// tb/tb_arb_hold_requester.sv - self-checking bench for arb_hold_requester
module tb_arb_hold_requester;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_len = '0;
    logic [3:0] cmd_tag = '0;
    logic       req, hold, gnt;
    logic       beat_fire, beat_last, done, err;
    logic [3:0] beat_idx, beat_tag;
    logic [7:0] wait_max;

    logic       tied_mode = 1'b1, rand_mode = 1'b0, force_drop = 1'b0;
    logic       rnd_bit = 1'b0, drop_bit = 1'b0;
    logic       comp_req = 1'b0, comp_hold = 1'b0;
    logic       arb_g0, arb_g1;
    logic [1:0] last_g;

    typedef struct {
        logic req, hold, gnt, fire, last, done, err, rdy, g0;
        logic [3:0] idx, tag;
        logic [7:0] wmax;
    } tr_t;

    tr_t        tr[$];
    logic [7:0] cmd_q[$];
    logic [7:0] acc_q[$];
    int         n_vec = 0, n_bad = 0;
    int         rst_cyc = -1, drop_cyc = -1, comp_cyc = -1;

    always #5 CLK = ~CLK;

    arb_hold_requester #(.LEN_W(4), .TAG_W(4), .WAIT_W(8)) dut (
        .CLK(CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_tag(cmd_tag), .req(req), .hold(hold), .gnt(gnt),
        .beat_fire(beat_fire), .beat_idx(beat_idx), .beat_last(beat_last),
        .beat_tag(beat_tag), .done(done), .err(err), .wait_max(wait_max)
    );

    // two-port hold round-robin arbiter: port 0 = competitor, port 1 = DUT
    always_comb begin
        arb_g0 = 1'b0;
        arb_g1 = 1'b0;
        if (last_g == 2'd1 && req && hold) arb_g1 = 1'b1;
        else if (last_g == 2'd0 && comp_req && comp_hold) arb_g0 = 1'b1;
        else if (last_g == 2'd0) begin
            if (req) arb_g1 = 1'b1;
            else if (comp_req) arb_g0 = 1'b1;
        end else begin
            if (comp_req) arb_g0 = 1'b1;
            else if (req) arb_g1 = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) last_g <= 2'd2;
        else if (arb_g0) last_g <= 2'd0;
        else if (arb_g1) last_g <= 2'd1;
    end

    assign gnt = force_drop ? 1'b0 :
                 tied_mode  ? req :
                 rand_mode  ? (req & (hold ? ~drop_bit : rnd_bit)) : arb_g1;

    task automatic begin_test();
        tr.delete();
        acc_q.delete();
        rst_cyc = -1;
        drop_cyc = -1;
        comp_cyc = -1;
    endtask

    task automatic do_reset();
        begin_test();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        logic hs = 1'b0;
        tr_t  e;
        for (int t = 0; t < n; t++) begin
            rst_n = 1'b1;
            if (hs) begin
                acc_q.push_back(cmd_q.pop_front());
                cmd_valid = 1'b0;
            end
            force_drop = (t == drop_cyc);
            if (t == comp_cyc) begin
                comp_req = 1'b0;
                comp_hold = 1'b0;
            end
            if (t == rst_cyc) rst_n = 1'b0;
            rnd_bit = 1'($urandom_range(0, 1));
            drop_bit = ($urandom_range(0, 15) == 0);
            if (!cmd_valid && cmd_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                cmd_valid = 1'b1;
                {cmd_len, cmd_tag} = cmd_q[0];
            end
            hs = cmd_valid & cmd_ready & rst_n;
            @(negedge CLK);
            e.req = req; e.hold = hold; e.gnt = gnt; e.fire = beat_fire; e.last = beat_last;
            e.done = done; e.err = err; e.rdy = cmd_ready; e.g0 = arb_g0;
            e.idx = beat_idx; e.tag = beat_tag; e.wmax = wait_max;
            tr.push_back(e);
            @(posedge CLK); #1;
        end
        if (hs) acc_q.push_back(cmd_q.pop_front());
        cmd_valid = 1'b0;
        force_drop = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        n_vec++; if ({req, hold, done, err, beat_fire, cmd_ready} !== 6'b000001) begin n_bad++; $display("FAIL reset_ctrl got %b exp 000001", {req, hold, done, err, beat_fire, cmd_ready}); end
        n_vec++; if (beat_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got %0d exp 0", beat_idx); end
        n_vec++; if (beat_tag !== 4'd0) begin n_bad++; $display("FAIL reset_tag got %0d exp 0", beat_tag); end
        n_vec++; if (wait_max !== 8'd0) begin n_bad++; $display("FAIL reset_wmax got %0d exp 0", wait_max); end
        @(posedge CLK); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int nf = 0, nh = 0;
        do_reset();
        tied_mode = 1'b1; rand_mode = 1'b0;
        cmd_q.push_back({4'd0, 4'd3});
        run(8);
        foreach (tr[i]) begin nf += int'(tr[i].fire); nh += int'(tr[i].hold); end
        n_vec++; if ({tr[2].fire, tr[2].last, tr[2].idx, tr[2].tag} !== {1'b1, 1'b1, 4'd0, 4'd3}) begin n_bad++; $display("FAIL single_beat got fire=%b last=%b idx=%0d tag=%0d exp 1 1 0 3", tr[2].fire, tr[2].last, tr[2].idx, tr[2].tag); end
        n_vec++; if ({tr[3].done, tr[3].req} !== 2'b10) begin n_bad++; $display("FAIL single_done got done=%b req=%b exp 1 0", tr[3].done, tr[3].req); end
        n_vec++; if (nf !== 1) begin n_bad++; $display("FAIL single_nfire got %0d exp 1", nf); end
        n_vec++; if (nh !== 0) begin n_bad++; $display("FAIL single_hold got %0d hold cycles exp 0", nh); end
    endtask

    task automatic test_burst4();
        do_reset();
        tied_mode = 1'b0; rand_mode = 1'b0;
        comp_req = 1'b1; comp_hold = 1'b0;
        cmd_q.push_back({4'd3, 4'hA});
        run(10);
        for (int i = 0; i < 4; i++) begin
            n_vec++; if ({tr[2+i].fire, tr[2+i].g0, tr[2+i].hold, tr[2+i].idx, tr[2+i].tag} !== {1'b1, 1'b0, (i > 0), 4'(i), 4'hA})
                begin n_bad++; $display("FAIL burst4_beat%0d got fire=%b g0=%b hold=%b idx=%0d tag=%0h", i, tr[2+i].fire, tr[2+i].g0, tr[2+i].hold, tr[2+i].idx, tr[2+i].tag); end
        end
        n_vec++; if ({tr[6].done, tr[6].req, tr[6].g0} !== 3'b101) begin n_bad++; $display("FAIL burst4_done got done=%b req=%b g0=%b exp 1 0 1", tr[6].done, tr[6].req, tr[6].g0); end
        comp_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nf = 0, nd = 0;
        do_reset();
        tied_mode = 1'b1; rand_mode = 1'b0;
        cmd_q.push_back({4'd1, 4'hB});
        cmd_q.push_back({4'd1, 4'hC});
        run(10);
        foreach (tr[i]) begin nf += int'(tr[i].fire); nd += int'(tr[i].done); end
        n_vec++; if ({tr[1].rdy, tr[2].rdy} !== 2'b01) begin n_bad++; $display("FAIL b2b_ready got %b exp 01", {tr[1].rdy, tr[2].rdy}); end
        n_vec++; if ({tr[3].fire, tr[3].idx, tr[3].last} !== {1'b1, 4'd1, 1'b1}) begin n_bad++; $display("FAIL b2b_beat1 got fire=%b idx=%0d last=%b", tr[3].fire, tr[3].idx, tr[3].last); end
        n_vec++; if ({tr[4].req, tr[4].done} !== 2'b01) begin n_bad++; $display("FAIL b2b_gap got req=%b done=%b exp 0 1", tr[4].req, tr[4].done); end
        n_vec++; if ({tr[5].fire, tr[5].idx, tr[5].tag} !== {1'b1, 4'd0, 4'hC}) begin n_bad++; $display("FAIL b2b_second got fire=%b idx=%0d tag=%0h exp 1 0 c", tr[5].fire, tr[5].idx, tr[5].tag); end
        n_vec++; if ({nf, nd} !== {32'd4, 32'd2}) begin n_bad++; $display("FAIL b2b_counts got fires=%0d dones=%0d exp 4 2", nf, nd); end
    endtask

    task automatic test_contention();
        do_reset();
        tied_mode = 1'b0; rand_mode = 1'b0;
        comp_req = 1'b1; comp_hold = 1'b1;
        comp_cyc = 8;
        cmd_q.push_back({4'd0, 4'd7});
        run(14);
        n_vec++; if ({tr[2].req, tr[2].gnt, tr[7].fire} !== 3'b100) begin n_bad++; $display("FAIL cont_wait got req=%b gnt=%b fire7=%b exp 1 0 0", tr[2].req, tr[2].gnt, tr[7].fire); end
        n_vec++; if (tr[8].fire !== 1'b1) begin n_bad++; $display("FAIL cont_fire got %b exp 1", tr[8].fire); end
        n_vec++; if (tr[9].wmax !== 8'd6) begin n_bad++; $display("FAIL cont_wmax got %0d exp 6", tr[9].wmax); end
    endtask

    task automatic test_grant_loss();
        int nd = 0;
        begin_test();
        tied_mode = 1'b1; rand_mode = 1'b0;
        drop_cyc = 4;
        cmd_q.push_back({4'd3, 4'd5});
        run(10);
        foreach (tr[i]) nd += int'(tr[i].done);
        n_vec++; if ({tr[4].hold, tr[4].fire, tr[4].err} !== 3'b100) begin n_bad++; $display("FAIL loss_drop got hold=%b fire=%b err=%b exp 1 0 0", tr[4].hold, tr[4].fire, tr[4].err); end
        n_vec++; if ({tr[5].req, tr[5].hold, tr[5].err, tr[5].fire, tr[5].idx} !== {4'b1011, 4'd2}) begin n_bad++; $display("FAIL loss_resume got req=%b hold=%b err=%b fire=%b idx=%0d exp 1 0 1 1 2", tr[5].req, tr[5].hold, tr[5].err, tr[5].fire, tr[5].idx); end
        n_vec++; if ({tr[6].fire, tr[6].idx, tr[6].last, tr[7].done} !== {1'b1, 4'd3, 2'b11}) begin n_bad++; $display("FAIL loss_finish got fire=%b idx=%0d last=%b done=%b", tr[6].fire, tr[6].idx, tr[6].last, tr[7].done); end
        n_vec++; if ({nd, tr[9].err} !== {32'd1, 1'b1}) begin n_bad++; $display("FAIL loss_sticky got dones=%0d err=%b exp 1 1", nd, tr[9].err); end
    endtask

    task automatic test_reset_mid_burst();
        int nq = 0;
        begin_test();
        tied_mode = 1'b1; rand_mode = 1'b0;
        rst_cyc = 3;
        cmd_q.push_back({4'd3, 4'd9});
        cmd_q.push_back({4'd0, 4'd5});
        run(10);
        for (int i = 4; i < 10; i++) nq += int'(tr[i].fire | tr[i].done);
        n_vec++; if ({tr[3].hold, tr[3].fire, tr[3].idx, tr[3].err} !== {2'b11, 4'd1, 1'b1}) begin n_bad++; $display("FAIL rmid_pre got hold=%b fire=%b idx=%0d err=%b exp 1 1 1 1", tr[3].hold, tr[3].fire, tr[3].idx, tr[3].err); end
        n_vec++; if ({tr[4].req, tr[4].hold, tr[4].rdy, tr[4].err, tr[4].wmax} !== {4'b0010, 8'd0}) begin n_bad++; $display("FAIL rmid_post got req=%b hold=%b rdy=%b err=%b wmax=%0d exp 0 0 1 0 0", tr[4].req, tr[4].hold, tr[4].rdy, tr[4].err, tr[4].wmax); end
        n_vec++; if (nq !== 0) begin n_bad++; $display("FAIL rmid_quiet got %0d fire/done cycles exp 0", nq); end
    endtask

    task automatic test_random();
        logic [8:0] exp_b[$];
        int k = 0, run_len = 0, dmis = 0, emis = 0, wmis = 0, fmis = 0;
        logic e_err = 1'b0;
        logic [7:0] e_w = '0;
        do_reset();
        tied_mode = 1'b0; rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) cmd_q.push_back(8'($urandom));
        run(1500);
        foreach (acc_q[i])
            for (int b = 0; b <= int'(acc_q[i][7:4]); b++)
                exp_b.push_back({acc_q[i][3:0], 4'(b), (b == int'(acc_q[i][7:4]))});
        foreach (tr[t]) begin
            if (tr[t].fire) begin
                n_vec++;
                if (k >= exp_b.size() || {tr[t].tag, tr[t].idx, tr[t].last} !== exp_b[k]) begin
                    n_bad++;
                    $display("FAIL rand_beat%0d got tag=%0h idx=%0d last=%b exp %h", k, tr[t].tag, tr[t].idx, tr[t].last, (k < exp_b.size()) ? exp_b[k] : 9'h1ff);
                end
                k++;
            end
            if (tr[t].done !== (t > 0 && tr[t-1].fire && tr[t-1].last)) dmis++;
            if (tr[t].fire !== (tr[t].req & tr[t].gnt)) fmis++;
            if (tr[t].err !== e_err) emis++;
            if (tr[t].wmax !== e_w) wmis++;
            if (tr[t].hold && !tr[t].gnt) e_err = 1'b1;
            if (tr[t].req && !tr[t].hold) begin
                if (tr[t].gnt) begin
                    if (8'(run_len) > e_w) e_w = 8'(run_len);
                    run_len = 0;
                end else if (run_len < 255) run_len++;
            end
        end
        n_vec++; if (k !== exp_b.size() || cmd_q.size() != 0) begin n_bad++; $display("FAIL rand_complete got %0d beats exp %0d (unsent %0d)", k, exp_b.size(), cmd_q.size()); end
        n_vec++; if (dmis !== 0) begin n_bad++; $display("FAIL rand_done got %0d bad cycles exp 0", dmis); end
        n_vec++; if (fmis !== 0) begin n_bad++; $display("FAIL rand_fire got %0d bad cycles exp 0", fmis); end
        n_vec++; if (emis !== 0) begin n_bad++; $display("FAIL rand_err got %0d bad cycles exp 0", emis); end
        n_vec++; if (wmis !== 0) begin n_bad++; $display("FAIL rand_wmax got %0d bad cycles exp 0", wmis); end
        rand_mode = 1'b0;
        cmd_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_back_to_back();
        test_contention();
        test_grant_loss();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
